// File: rtl/pixel2map_pkg.sv
// Shared types and constants for the pixel -> map coordinate translator.
package pixel2map_pkg;

   // Zoom select; the value is the right-shift applied to screen offsets.
   typedef enum logic [1:0] {
      Z1 = 2'd0,
      Z2 = 2'd1,
      Z4 = 2'd2,
      Z8 = 2'd3
   } zoom_e;

   localparam int DEF_COORD_W  = 9;
   localparam int DEF_SCREEN_W = 320;
   localparam int DEF_SCREEN_H = 240;
   localparam int DEF_MAP_W    = 320;
   localparam int DEF_MAP_H    = 240;
   localparam int DEF_RATE_W   = 2;

   localparam int HALF_W = DEF_SCREEN_W / 2;
   localparam int HALF_H = DEF_SCREEN_H / 2;

   // Signed intermediate width: two extra bits hold the sum of two
   // coordinates and the sign of a negative offset without truncation.
   function automatic int calc_sw(input int coord_w);
      return coord_w + 2;
   endfunction

endpackage

// File: rtl/pixel2map_axis.sv
// One axis of the translator: shift by zoom, add view centre, subtract the
// zoomed half-screen, then bound-check against the map and optionally clamp.
module pixel2map_axis
   import pixel2map_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int SCREEN  = DEF_SCREEN_W,
   parameter int MAP     = DEF_MAP_W,
   parameter int RATE_W  = DEF_RATE_W,
   parameter int CLAMP   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s1_en,
   input  logic               s2_en,
   input  logic [COORD_W-1:0] pixel,
   input  logic [COORD_W-1:0] centre,
   input  logic [RATE_W-1:0]  rate,
   output logic [COORD_W-1:0] coord,
   output logic               oob
);

   localparam int TW = calc_sw(COORD_W);
   localparam logic signed [TW-1:0] HALF    = TW'(SCREEN / 2);
   localparam logic signed [TW-1:0] MAP_S   = TW'(MAP);
   localparam logic [COORD_W-1:0]   MAP_MAX = COORD_W'(MAP - 1);

   logic [COORD_W-1:0]     pix_sh;
   logic signed [TW-1:0]   half_sh;
   logic signed [TW-1:0]   t_d, t_q;
   logic [COORD_W-1:0]     coord_d, coord_q;
   logic                   oob_d, oob_q;
   logic                   neg, over;

   // Stage 1: signed offset from the view centre at the current zoom.
   always_comb begin
      pix_sh  = pixel >> rate;
      half_sh = HALF >>> rate;
      t_d     = t_q;
      if (s1_en) begin
         t_d = $signed({2'b00, pix_sh}) + $signed({2'b00, centre}) - half_sh;
      end
   end

   // Stage 2: bound check on the full-width value, then clamp or wrap.
   always_comb begin
      neg     = t_q[TW-1];
      over    = (t_q >= MAP_S);
      oob_d   = oob_q;
      coord_d = coord_q;
      if (s2_en) begin
         oob_d = neg | over;
         if ((CLAMP != 0) && neg) begin
            coord_d = '0;
         end else if ((CLAMP != 0) && over) begin
            coord_d = MAP_MAX;
         end else begin
            coord_d = t_q[COORD_W-1:0];
         end
      end
   end

   // Pipeline registers for both stages.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         t_q     <= '0;
         coord_q <= '0;
         oob_q   <= 1'b0;
      end else begin
         t_q     <= t_d;
         coord_q <= coord_d;
         oob_q   <= oob_d;
      end
   end

   assign coord = coord_q;
   assign oob   = oob_q;

endmodule

// File: rtl/pixel2map_stream.sv
// Streaming pixel -> map translator: per-frame view shadow registers, a
// two-stage valid pipeline with valid/ready flow control, and two axis slices.
module pixel2map_stream
   import pixel2map_pkg::*;
#(
   parameter int COORD_W  = DEF_COORD_W,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int MAP_W    = DEF_MAP_W,
   parameter int MAP_H    = DEF_MAP_H,
   parameter int RATE_W   = DEF_RATE_W,
   parameter int CLAMP    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] m,
   input  logic [COORD_W-1:0] n,
   input  logic [RATE_W-1:0]  rate,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COORD_W-1:0] map_x,
   output logic [COORD_W-1:0] map_y,
   output logic               out_of_map
);

   logic [COORD_W-1:0] m_s_d, m_s_q;
   logic [COORD_W-1:0] n_s_d, n_s_q;
   logic [RATE_W-1:0]  rate_s_d, rate_s_q;
   logic               s1_valid_d, s1_valid_q;
   logic               s2_valid_d, s2_valid_q;
   logic               move;
   logic               oob_x, oob_y;

   // The whole pipeline advances together whenever the output slot is free
   // or being drained this cycle.
   assign move     = !s2_valid_q || out_ready;
   assign in_ready = move;

   // View shadow; the _d value feeds stage 1 so a pixel arriving with
   // frame_start already sees the new view.
   always_comb begin
      m_s_d    = m_s_q;
      n_s_d    = n_s_q;
      rate_s_d = rate_s_q;
      if (frame_start) begin
         m_s_d    = m;
         n_s_d    = n;
         rate_s_d = rate;
      end
   end

   // Valid bits shadow the data through both stages.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (move) begin
         s1_valid_d = in_valid;
         s2_valid_d = s1_valid_q;
      end
   end

   // View and valid registers; reset discards anything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_s_q      <= '0;
         n_s_q      <= '0;
         rate_s_q   <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         m_s_q      <= m_s_d;
         n_s_q      <= n_s_d;
         rate_s_q   <= rate_s_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   pixel2map_axis #(
      .COORD_W (COORD_W),
      .SCREEN  (SCREEN_W),
      .MAP     (MAP_W),
      .RATE_W  (RATE_W),
      .CLAMP   (CLAMP)
   ) u_axis_x (
      .clk    (clk),
      .rst_n  (rst_n),
      .s1_en  (move),
      .s2_en  (move),
      .pixel  (pixel_x),
      .centre (m_s_d),
      .rate   (rate_s_d),
      .coord  (map_x),
      .oob    (oob_x)
   );

   pixel2map_axis #(
      .COORD_W (COORD_W),
      .SCREEN  (SCREEN_H),
      .MAP     (MAP_H),
      .RATE_W  (RATE_W),
      .CLAMP   (CLAMP)
   ) u_axis_y (
      .clk    (clk),
      .rst_n  (rst_n),
      .s1_en  (move),
      .s2_en  (move),
      .pixel  (pixel_y),
      .centre (n_s_d),
      .rate   (rate_s_d),
      .coord  (map_y),
      .oob    (oob_y)
   );

   assign out_valid  = s2_valid_q;
   assign out_of_map = oob_x | oob_y;

endmodule

// File: tb/tb_pixel2map_stream.sv
// Scoreboard bench for pixel2map_stream: expected results are computed from
// the translation rules with integer arithmetic when a pixel is accepted and
// compared in order whenever a result is transferred.
module tb_pixel2map_stream;
   import pixel2map_pkg::*;

   localparam int CW = 9;
   localparam int SW = 320;
   localparam int SH = 240;
   localparam int MW = 320;
   localparam int MH = 240;
   localparam int RW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic [CW-1:0] m = '0;
   logic [CW-1:0] n = '0;
   logic [RW-1:0] rate = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] pixel_x = '0;
   logic [CW-1:0] pixel_y = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] map_x;
   logic [CW-1:0] map_y;
   logic          out_of_map;

   pixel2map_stream #(
      .COORD_W (CW), .SCREEN_W (SW), .SCREEN_H (SH),
      .MAP_W (MW), .MAP_H (MH), .RATE_W (RW), .CLAMP (1)
   ) dut (
      .clk (clk), .rst_n (rst_n), .frame_start (frame_start),
      .m (m), .n (n), .rate (rate),
      .in_valid (in_valid), .in_ready (in_ready),
      .pixel_x (pixel_x), .pixel_y (pixel_y),
      .out_valid (out_valid), .out_ready (out_ready),
      .map_x (map_x), .map_y (map_y), .out_of_map (out_of_map)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit oob;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_popped = 0;
   int   bp_mode  = 0;
   int   bp_cnt   = 0;
   int   sh_m = 0, sh_n = 0, sh_r = 0;
   bit   prev_stall = 0;
   int   prev_x = 0, prev_y = 0, prev_o = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: zoomed offset from the view centre, clamped into the map.
   function automatic void ref_axis(input int pix, input int ctr, input int r,
                                    input int half, input int mp,
                                    output int coord, output bit oob);
      int t;
      t = (pix / (1 << r)) + ctr - (half / (1 << r));
      oob = (t < 0) || (t >= mp);
      if (t < 0) coord = 0;
      else if (t >= mp) coord = mp - 1;
      else coord = t;
   endfunction

   // Scoreboard: push on acceptance, pop and compare on transfer.
   always @(negedge clk) begin
      exp_t e;
      bit   ox, oy;
      if (!rst_n) begin
         q.delete();
         sh_m = 0; sh_n = 0; sh_r = 0;
         prev_stall = 0;
      end else begin
         if (frame_start) begin
            sh_m = int'(m); sh_n = int'(n); sh_r = int'(rate);
         end
         if (in_valid && in_ready) begin
            ref_axis(int'(pixel_x), sh_m, sh_r, HALF_W, MW, e.x, ox);
            ref_axis(int'(pixel_y), sh_n, sh_r, HALF_H, MH, e.y, oy);
            e.oob = ox | oy;
            q.push_back(e);
         end
         if (prev_stall) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_map_x", int'(map_x), prev_x);
            chk("stall_map_y", int'(map_y), prev_y);
            chk("stall_oob", int'(out_of_map), prev_o);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output: got x=%0d y=%0d, expected no output at %0t",
                        map_x, map_y, $time);
            end else begin
               e = q.pop_front();
               n_popped++;
               chk("map_x", int'(map_x), e.x);
               chk("map_y", int'(map_y), e.y);
               chk("out_of_map", int'(out_of_map), int'(e.oob));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_x = int'(map_x); prev_y = int'(map_y); prev_o = int'(out_of_map);
      end
   end

   // Downstream ready pattern.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               out_ready = !(bp_cnt >= 3 && bp_cnt <= 6);
               bp_cnt++;
            end
            3: out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic idle(input int k);
      in_valid = 1'b0;
      repeat (k) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic view(input int vm, input int vn, input int vr);
      frame_start = 1'b1;
      m = CW'(vm); n = CW'(vn); rate = RW'(vr);
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   // Present one pixel and hold it until accepted; leaves in_valid high.
   task automatic send(input int px, input int py, input bit fs,
                       input int fm, input int fn, input int fr);
      bit acc;
      bit done;
      done = 0;
      frame_start = fs;
      if (fs) begin
         m = CW'(fm); n = CW'(fn); rate = RW'(fr);
      end
      pixel_x = CW'(px);
      pixel_y = CW'(py);
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         frame_start = 1'b0;
         if (acc) done = 1;
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      bp_mode = 0;
      for (int i = 0; i < 100 && q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      idle(4);
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      int pop0;
      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_map_x", int'(map_x), 0);
      chk("rst_map_y", int'(map_y), 0);
      chk("rst_oob", int'(out_of_map), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // Zoom 1 centred view, latency check on pixel (0,0).
      view(160, 120, int'(Z1));
      idle(2);
      send(0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_cycle1", int'(out_valid), 0);
      @(negedge clk);
      chk("latency_cycle2", int'(out_valid), 1);
      @(posedge clk); #1;

      // Zoom 8 and the map-edge cases.
      view(100, 50, int'(Z8));
      send(319, 239, 0, 0, 0, 0);
      send(0, 0, 1, 10, 10, 0);
      send(319, 120, 1, 319, 120, 0);
      send(160, 120, 0, 0, 0, 0);
      idle(1);

      // View inputs moving mid-frame are ignored.
      view(160, 120, 0);
      rate = 2'd2; m = 9'd7; n = 9'd300;
      send(200, 100, 0, 0, 0, 0);
      send(37, 5, 0, 0, 0, 0);
      // Same-cycle frame_start and pixel: pixel sees the new view.
      send(200, 100, 1, 160, 120, 2);
      send(300, 230, 0, 0, 0, 0);
      drain();

      // Ten-pixel burst with downstream stalled in cycles 3..6.
      pop0 = n_popped;
      view(200, 100, 1);
      bp_cnt = 0;
      bp_mode = 2;
      for (int i = 0; i < 10; i++) send(i * 31, i * 23, 0, 0, 0, 0);
      drain();
      chk("burst_count", n_popped - pop0, 10);

      // Reset with two pixels held in flight.
      bp_mode = 3;
      idle(2);
      send(10, 10, 0, 0, 0, 0);
      send(20, 20, 0, 0, 0, 0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      bp_mode = 0;
      idle(6);
      chk("midrst_dropped", q.size(), 0);

      // Randomised traffic with random backpressure and view changes.
      bp_mode = 1;
      view(160, 120, 0);
      repeat (400) begin
         m = CW'($urandom); n = CW'($urandom); rate = RW'($urandom);
         if ($urandom_range(0, 3) == 0) idle(1);
         send($urandom_range(0, SW - 1), $urandom_range(0, SH - 1),
              ($urandom_range(0, 15) == 0),
              $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 3));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
